// File: rtl/maze_pkg.sv
// Shared definitions for the maze move controller.
// Holds the FSM state type, the key/direction encoding used on move and s_obs,
// the position-register select codes and the two pixel colours.
package maze_pkg;

  typedef enum logic [3:0] {
    StInit,
    StDraw,
    StIdle,
    StProbe,
    StRead,
    StCheck,
    StErase,
    StStep,
    StDrawNew,
    StHold,
    StWin
  } state_e;

  // Key / direction encoding; 5..7 are treated as no key.
  localparam logic [2:0] MoveNone  = 3'd0;
  localparam logic [2:0] MoveLeft  = 3'd1;
  localparam logic [2:0] MoveRight = 3'd2;
  localparam logic [2:0] MoveUp    = 3'd3;
  localparam logic [2:0] MoveDown  = 3'd4;

  // Position register selects.
  localparam logic [1:0] SelInit = 2'd0;
  localparam logic [1:0] SelInc  = 2'd1;
  localparam logic [1:0] SelDec  = 2'd2;

  localparam logic ColorTrail  = 1'b0;
  localparam logic ColorPlayer = 1'b1;

  function automatic logic is_dir(logic [2:0] m);
    return (m >= MoveLeft) && (m <= MoveDown);
  endfunction

endpackage

// File: rtl/maze_move_ctrl.sv
// Moore FSM sequencing the maze datapath: captures an arrow-key move, probes
// the obstacle memory at the target pixel, erases and redraws the player and
// paces successive moves with the datapath timer.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   move                   decoded key (0 none, 1 left, 2 right, 3 up, 4 down)
//   obs_block              target pixel is a wall
//   timer_done             move-pacing timer expired
//   xpos, ypos             current player position
//   en_xpos/s_xpos,
//   en_ypos/s_ypos         position register enables / selects
//   en_key/s_key           key register enable / capture(1) or clear(0)
//   en_obs/s_obs           obstacle-address register enable / probe direction
//   s_color, plot          pixel colour select / VGA write strobe
//   en_timer/s_timer       timer enable / count(1) or clear(0)
//   did_win                goal reached
module maze_move_ctrl
  import maze_pkg::*;
#(
  parameter logic [7:0]  GOAL_X  = 8'h05,
  parameter logic [6:0]  GOAL_Y  = 7'h05,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] move,
  input  logic       obs_block,
  input  logic       timer_done,
  input  logic [7:0] xpos,
  input  logic [6:0] ypos,
  output logic       en_xpos,
  output logic [1:0] s_xpos,
  output logic       en_ypos,
  output logic [1:0] s_ypos,
  output logic       en_key,
  output logic       s_key,
  output logic       en_obs,
  output logic [2:0] s_obs,
  output logic       s_color,
  output logic       plot,
  output logic       en_timer,
  output logic       s_timer,
  output logic       did_win
);

  // S_READ spans MEM_LAT cycles, so PROBE to CHECK takes MEM_LAT+1 cycles.
  localparam logic [1:0] LastCnt = 2'(MEM_LAT - 1);

  state_e     state_q, state_d;
  logic [2:0] dir_q, dir_d;
  logic [1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StInit;
      dir_q   <= MoveNone;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit:  state_d = StDraw;
      StDraw:  state_d = StIdle;
      StIdle: begin
        if (is_dir(move)) begin
          dir_d   = move;
          state_d = StProbe;
        end
      end
      StProbe: begin
        cnt_d   = 2'd0;
        state_d = StRead;
      end
      StRead: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == LastCnt) state_d = StCheck;
      end
      StCheck:   state_d = obs_block ? StHold : StErase;
      StErase:   state_d = StStep;
      StStep:    state_d = StDrawNew;
      // xpos/ypos already reflect the step taken in StStep.
      StDrawNew: state_d = ((xpos == GOAL_X) && (ypos == GOAL_Y)) ? StWin : StHold;
      StHold: begin
        if (timer_done) state_d = StIdle;
      end
      StWin:     state_d = StWin;
      default:   state_d = StInit;
    endcase
  end

  // Moore output decode.
  always_comb begin
    en_xpos  = 1'b0;
    s_xpos   = SelInit;
    en_ypos  = 1'b0;
    s_ypos   = SelInit;
    en_key   = 1'b0;
    s_key    = 1'b0;
    en_obs   = 1'b0;
    s_obs    = MoveNone;
    s_color  = ColorTrail;
    plot     = 1'b0;
    en_timer = 1'b0;
    s_timer  = 1'b0;
    did_win  = 1'b0;
    unique case (state_q)
      StInit: begin
        en_xpos  = 1'b1;
        en_ypos  = 1'b1;
        en_timer = 1'b1;
        en_key   = 1'b1;
      end
      StDraw, StDrawNew: begin
        plot    = 1'b1;
        s_color = ColorPlayer;
      end
      StIdle: begin
        en_key   = 1'b1;
        s_key    = 1'b1;
        en_timer = 1'b1;
      end
      StProbe: begin
        en_obs = 1'b1;
        s_obs  = dir_q;
      end
      StErase: begin
        plot    = 1'b1;
        s_color = ColorTrail;
      end
      StStep: begin
        unique case (dir_q)
          MoveLeft:  begin en_xpos = 1'b1; s_xpos = SelDec; end
          MoveRight: begin en_xpos = 1'b1; s_xpos = SelInc; end
          MoveUp:    begin en_ypos = 1'b1; s_ypos = SelDec; end
          MoveDown:  begin en_ypos = 1'b1; s_ypos = SelInc; end
          default:   ;
        endcase
      end
      StHold: begin
        en_timer = 1'b1;
        s_timer  = 1'b1;
        en_key   = 1'b1;
      end
      StWin:   did_win = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Bench for maze_move_ctrl: a small datapath stand-in (position registers and
// pacing timer) plus a transaction-level model that predicts the output vector
// every cycle, and directed checks of hand-computed values.
module tb_maze_move_ctrl;

  localparam int         MEM_LAT = 2;
  localparam logic [7:0] GOAL_X  = 8'h05;
  localparam logic [6:0] GOAL_Y  = 7'h05;
  localparam int         TPER    = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] move = 3'd0;
  logic       obs_block = 1'b0;
  logic       timer_done;
  logic [7:0] xpos = 8'd10;
  logic [6:0] ypos = 7'd20;
  logic       en_xpos, en_ypos, en_key, s_key, en_obs, s_color, plot, en_timer, s_timer;
  logic       did_win;
  logic [1:0] s_xpos, s_ypos;
  logic [2:0] s_obs;

  always #5 clk = ~clk;

  maze_move_ctrl #(
    .GOAL_X (GOAL_X),
    .GOAL_Y (GOAL_Y),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .move      (move),
    .obs_block (obs_block),
    .timer_done(timer_done),
    .xpos      (xpos),
    .ypos      (ypos),
    .en_xpos   (en_xpos),
    .s_xpos    (s_xpos),
    .en_ypos   (en_ypos),
    .s_ypos    (s_ypos),
    .en_key    (en_key),
    .s_key     (s_key),
    .en_obs    (en_obs),
    .s_obs     (s_obs),
    .s_color   (s_color),
    .plot      (plot),
    .en_timer  (en_timer),
    .s_timer   (s_timer),
    .did_win   (did_win)
  );

  typedef struct packed {
    logic       en_xpos;
    logic [1:0] s_xpos;
    logic       en_ypos;
    logic [1:0] s_ypos;
    logic       en_key;
    logic       s_key;
    logic       en_obs;
    logic [2:0] s_obs;
    logic       s_color;
    logic       plot;
    logic       en_timer;
    logic       s_timer;
    logic       did_win;
  } outv_t;

  outv_t act, cap;
  assign act = outv_t'({en_xpos, s_xpos, en_ypos, s_ypos, en_key, s_key, en_obs, s_obs,
                        s_color, plot, en_timer, s_timer, did_win});

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  // ---------------- datapath stand-in ----------------
  logic [7:0] init_x = 8'd10;
  logic [6:0] init_y = 7'd20;
  logic [3:0] tcnt = 4'd0;

  always @(negedge clk) cap = act;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cap.en_xpos === 1'b1)
      xpos <= (cap.s_xpos == 2'd0) ? init_x : (cap.s_xpos == 2'd1) ? xpos + 8'd1 : xpos - 8'd1;
    if (cap.en_ypos === 1'b1)
      ypos <= (cap.s_ypos == 2'd0) ? init_y : (cap.s_ypos == 2'd1) ? ypos + 7'd1 : ypos - 7'd1;
    if (cap.en_timer === 1'b1) tcnt <= cap.s_timer ? tcnt + 4'd1 : 4'd0;
  end
  assign timer_done = (tcnt == 4'(TPER));

  // ---------------- transaction-level model ----------------
  function automatic outv_t zero_v();
    outv_t v = '0;
    return v;
  endfunction
  function automatic outv_t idle_v();
    outv_t v = '0;
    v.en_key = 1; v.s_key = 1; v.en_timer = 1;
    return v;
  endfunction
  function automatic outv_t hold_v();
    outv_t v = '0;
    v.en_key = 1; v.en_timer = 1; v.s_timer = 1;
    return v;
  endfunction
  function automatic outv_t plot_v(logic color);
    outv_t v = '0;
    v.plot = 1; v.s_color = color;
    return v;
  endfunction
  function automatic outv_t rest_v(int r);
    outv_t v = '0;
    if (r == 0) v = idle_v();
    else if (r == 1) v = hold_v();
    else v.did_win = 1;
    return v;
  endfunction

  outv_t exp_v;
  outv_t pend[$];
  int    rest = 0;      // 0 waiting for key, 1 pacing hold, 2 won
  bit    in_rest = 0;
  bit    mvalid = 0;

  task automatic accept();
    outv_t v;
    logic [7:0] nx;
    logic [6:0] ny;
    nx = xpos;
    ny = ypos;
    v = zero_v(); v.en_obs = 1; v.s_obs = move;
    exp_v = v;
    repeat (MEM_LAT + 1) pend.push_back(zero_v());  // memory wait plus decision cycle
    if (obs_block) begin
      rest = 1;
    end else begin
      pend.push_back(plot_v(1'b0));
      v = zero_v();
      case (move)
        3'd1: begin v.en_xpos = 1; v.s_xpos = 2'd2; nx = xpos - 8'd1; end
        3'd2: begin v.en_xpos = 1; v.s_xpos = 2'd1; nx = xpos + 8'd1; end
        3'd3: begin v.en_ypos = 1; v.s_ypos = 2'd2; ny = ypos - 7'd1; end
        default: begin v.en_ypos = 1; v.s_ypos = 2'd1; ny = ypos + 7'd1; end
      endcase
      pend.push_back(v);
      pend.push_back(plot_v(1'b1));
      rest = (nx == GOAL_X && ny == GOAL_Y) ? 2 : 1;
    end
    in_rest = 0;
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      pend.delete();
      pend.push_back(plot_v(1'b1));
      exp_v = zero_v();
      exp_v.en_xpos = 1; exp_v.en_ypos = 1; exp_v.en_timer = 1; exp_v.en_key = 1;
      rest = 0;
      in_rest = 0;
      mvalid = 1;
    end else if (mvalid) begin
      if (pend.size() > 0) exp_v = pend.pop_front();
      else if (!in_rest) begin
        in_rest = 1;
        exp_v = rest_v(rest);
      end else if (rest == 0) begin
        if (move >= 3'd1 && move <= 3'd4) accept();
      end else if (rest == 1) begin
        if (timer_done) begin
          rest = 0;
          exp_v = idle_v();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) chk($sformatf("cycle%0d_outputs", cyc), 32'(act), 32'(exp_v));
  end

  // ---------------- event recorders (cumulative) ----------------
  int probe_cyc = -1, probe_dir = -1, erase_cyc = -1, step_cyc = -1, step_sel = -1;
  int redraw_cyc = -1;
  int plots = 0, ysteps = 0, yinc = 0, tdone_mid = 0, xsteps = 0;

  always @(negedge clk) begin
    if (en_obs) begin probe_cyc = cyc; probe_dir = int'(s_obs); end
    if (plot) plots++;
    if (plot && !s_color) erase_cyc = cyc;
    if (plot && s_color) redraw_cyc = cyc;
    if (en_xpos && s_xpos != 2'd0) begin xsteps++; step_cyc = cyc; step_sel = int'(s_xpos); end
    if (en_ypos && s_ypos != 2'd0) ysteps++;
    if (timer_done && yinc >= 1 && yinc < 3) tdone_mid++;
    if (en_ypos && s_ypos == 2'd1) yinc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string name);
    bit found = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      #1;
      if (en_key && s_key) found = 1;
    end
    if (!found) chk({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    resetn = 0;
    tick();
    tick();
    resetn = 1;
    wait_idle("reset");
  endtask

  task automatic press(logic [2:0] k);
    tick();
    move = k;
    tick();
    move = 3'd0;
  endtask

  int mcyc, p0, ys0, xs0;
  bit hit;

  initial begin
    // Reset sequence with literal expectations.
    tick();
    tick();
    resetn = 1;
    @(negedge clk);
    chk("init_en_xpos", en_xpos, 1);
    chk("init_en_ypos", en_ypos, 1);
    chk("init_sel", {s_xpos, s_ypos}, 0);
    @(negedge clk);
    chk("init_draw", {plot, s_color}, 2'b11);
    @(negedge clk);
    chk("init_idle_key", {en_key, s_key}, 2'b11);
    chk("init_pos", {xpos, 1'b0, ypos}, {8'd10, 1'b0, 7'd20});

    // Free move right.
    tick();
    move = 3'd2;
    mcyc = cyc;
    tick();
    move = 3'd0;
    wait_idle("free");
    chk("free_probe_latency", probe_cyc - mcyc, 1);
    chk("free_probe_dir", probe_dir, 2);
    chk("free_erase_after_probe", erase_cyc - probe_cyc, 4);
    chk("free_step_after_erase", step_cyc - erase_cyc, 1);
    chk("free_step_sel", step_sel, 1);
    chk("free_redraw_after_step", redraw_cyc - step_cyc, 1);
    chk("free_xpos", xpos, 11);

    // Blocked move up.
    obs_block = 1;
    p0 = plots;
    ys0 = ysteps;
    press(3'd3);
    wait_idle("blocked");
    obs_block = 0;
    chk("blocked_plots", plots - p0, 0);
    chk("blocked_ysteps", ysteps - ys0, 0);
    chk("blocked_ypos", ypos, 20);

    // Held down key: one step per timer period.
    tick();
    move = 3'd4;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (yinc >= 3) hit = 1;
    end
    move = 3'd0;
    chk("pace_reached", hit, 1);
    wait_idle("pace");
    chk("pace_steps", yinc, 3);
    chk("pace_tdone_between", tdone_mid, 2);
    chk("pace_ypos", ypos, 23);

    // Win: start one pixel right of the goal and step left.
    init_x = 8'd6;
    init_y = 7'd5;
    do_reset();
    chk("win_start", {xpos, 1'b0, ypos}, {8'd6, 1'b0, 7'd5});
    press(3'd1);
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (did_win) hit = 1;
    end
    chk("win_reached", hit, 1);
    move = 3'd2;
    repeat (6) tick();
    move = 3'd0;
    chk("win_held", did_win, 1);
    chk("win_xpos", xpos, 5);

    // Reset during the erase of a move.
    init_x = 8'd10;
    init_y = 7'd20;
    do_reset();
    press(3'd2);
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (plot && !s_color) hit = 1;
    end
    chk("midop_erase_seen", hit, 1);
    xs0 = xsteps;
    resetn = 0;
    @(negedge clk);
    chk("midop_init", {en_xpos, s_xpos, en_ypos, s_ypos}, 6'b100100);
    chk("midop_did_win", did_win, 0);
    tick();
    resetn = 1;
    wait_idle("midop");
    repeat (4) tick();
    chk("midop_no_step", xsteps - xs0, 0);
    chk("midop_xpos", xpos, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/maze_move_ctrl.md
Name: maze_move_ctrl

Overview:
- Moore FSM that sequences the maze datapath: captures arrow-key moves, probes the obstacle memory at the target pixel, erases/redraws the player on VGA, and paces moves with the datapath timer.
- Sits between the PS/2 key path and the datapath. It drives every datapath enable/select plus `plot`, and reads back `move`, `obs_block`, `timer_done` and the player position.

Parameters:
- GOAL_X, 8'h05: goal pixel column; reaching it ends the game.
- GOAL_Y, 7'h05: goal pixel row.
- MEM_LAT, 2: obstacle-memory read latency in cycles, from obs_x/obs_y registered to obs_mem valid; legal range 1..3.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- move  in  3  decoded key from datapath: 0 none, 1 left, 2 right, 3 up, 4 down; 5..7 are treated as none
- obs_block  in  1  target pixel is a wall (obstacle colour BLACK)
- timer_done  in  1  move-pacing timer reached its limit
- xpos  in  8  current player column
- ypos  in  7  current player row
- en_xpos  out  1  xpos load enable
- s_xpos  out  2  0 init, 1 +1, 2 -1
- en_ypos  out  1  ypos load enable
- s_ypos  out  2  0 init, 1 +1, 2 -1
- en_key  out  1  key register enable
- s_key  out  1  1 capture keycode, 0 clear
- en_obs  out  1  obstacle-address register enable
- s_obs  out  3  probe direction; encoding identical to move
- s_color  out  1  1 player (RED), 0 trail colour
- plot  out  1  VGA write strobe, one cycle per pixel
- en_timer  out  1  timer enable
- s_timer  out  1  1 count, 0 clear
- did_win  out  1  high once the goal is reached

Behaviour:
- State register plus a 3-bit `dir` register and a 2-bit latency counter. All outputs are pure decodes of state/dir (Moore). Any output not listed for a state is 0.
- Reset: resetn low at a clk edge forces S_INIT, dir=0, counter=0 regardless of current state, including mid-erase or mid-draw. No partial-pixel recovery is needed. did_win=0 after reset.
- S_INIT:
  - en_xpos=1, s_xpos=0; en_ypos=1, s_ypos=0; en_timer=1, s_timer=0; en_key=1, s_key=0.
  - Next: S_DRAW.
- S_DRAW: plot=1, s_color=1. Next: S_IDLE.
- S_IDLE:
  - en_key=1, s_key=1; en_timer=1, s_timer=0.
  - If move is in 1..4: latch dir<=move and go to S_PROBE. Otherwise stay.
- S_PROBE: en_obs=1, s_obs=dir; counter<=0. Next: S_READ.
- S_READ: counter increments each cycle. Leave for S_CHECK when counter==MEM_LAT-1.
  - Total latency from S_PROBE to S_CHECK is MEM_LAT+1 cycles.
- S_CHECK:
  - obs_block=1: go to S_HOLD. Position unchanged, nothing plotted.
  - obs_block=0: go to S_ERASE.
- S_ERASE: plot=1, s_color=0 (repaints the old position as trail). Next: S_STEP.
- S_STEP:
  - dir=1: en_xpos=1, s_xpos=2.
  - dir=2: en_xpos=1, s_xpos=1.
  - dir=3: en_ypos=1, s_ypos=2.
  - dir=4: en_ypos=1, s_ypos=1.
  - Next: S_DRAW_NEW.
- S_DRAW_NEW: plot=1, s_color=1.
  - If xpos==GOAL_X and ypos==GOAL_Y (already updated): go to S_WIN.
  - Otherwise: go to S_HOLD.
- S_HOLD:
  - en_timer=1, s_timer=1; en_key=1, s_key=0 (discards keys pressed during the hold).
  - When timer_done=1: go to S_IDLE.
- S_WIN: did_win=1, all enables 0, plot=0. Terminal until reset.
- Boundaries:
  - No coordinate clamping; walls in obstacle memory bound the maze. Wrap-around of xpos/ypos is the datapath's behaviour and is not checked here.
  - A held key repeats one move per timer period.
  - A key arriving at the same edge as the S_HOLD→S_IDLE transition is lost; this is accepted.
- Invariants:
  - plot is never high in two consecutive cycles.
  - en_xpos and en_ypos are never high together except in S_INIT.

Decomposition:
- Shared package `maze_pkg`:
  - state enum.
  - move/dir encodings (NONE, LEFT, RIGHT, UP, DOWN).
  - s_xpos/s_ypos selects (SEL_INIT, SEL_INC, SEL_DEC).
  - colour constants.
- No sub-module; a single FSM file with a separate output-decode block.

Test Plan:
- Reset: resetn=0 for 2 cycles, then release. Required: S_INIT asserts en_xpos/en_ypos with selects 0, then exactly one plot with s_color=1, then S_IDLE with en_key=s_key=1.
- Free move: move=2, obs_block=0, MEM_LAT=2. Required:
  - s_obs=2 in the cycle after move seen.
  - plot(s_color=0) 4 cycles after S_PROBE.
  - next cycle en_xpos=1, s_xpos=2'd1.
  - next cycle plot with s_color=1.
  - then en_timer with s_timer=1 until timer_done.
- Blocked move: move=3, obs_block=1. Required: no plot, no en_ypos, straight to S_HOLD.
- Pacing: hold move=4 for 3 timer periods. Required: exactly 3 en_ypos pulses with s_ypos=1, each separated by one timer_done.
- Win: player one step right of the goal, move=1, obs_block=0. Required: after the redraw plot, did_win=1 held. Further move inputs produce no enables.
- Reset mid-op: resetn=0 during S_ERASE. Required: next cycle is S_INIT, did_win=0, dir=0, and no S_STEP enables ever issued.
